// File: rtl/joy_db15_responder.sv
// rtl/joy_db15_responder.sv - DB15 joystick responder emulating the SNAC 74HC165 shift chain
module joy_db15_responder #(
  parameter int BITS_PER_PLAYER = 12,
  parameter int TIMEOUT_CYCLES  = 2_500_000
) (
  input  logic                       Clk_50_I,
  input  logic                       Reset_n,
  input  logic                       JOY_CLK,
  input  logic                       JOY_LOAD,
  input  logic [BITS_PER_PLAYER-1:0] joystick1,
  input  logic [BITS_PER_PLAYER-1:0] joystick2,
  output logic                       JOY_DATA,
  output logic                       frame_done,
  output logic                       link_active,
  output logic [4:0]                 bit_count
);

  localparam int              FRAME     = 2 * BITS_PER_PLAYER;
  localparam logic [4:0]      FRAME_LEN = 5'(FRAME);
  localparam int              WD_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX    = WD_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_DONE} state_t;

  logic            clk_meta_q, clk_sync_q, clk_prev_q;
  logic            load_meta_q, load_sync_q;
  state_t          state_q, state_d;
  logic [FRAME-1:0] sr_q, sr_d;
  logic [4:0]      cnt_q, cnt_d;
  logic            done_q, done_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            link_q, link_d;
  logic            clk_rise;

  assign clk_rise = clk_sync_q & ~clk_prev_q;

  // The load synchronizer resets to the idle (high) level so a quiet host
  // leaves the chain parked in IDLE with JOY_DATA high.
  always_ff @(posedge Clk_50_I or negedge Reset_n) begin
    if (!Reset_n) begin
      clk_meta_q  <= 1'b0;
      clk_sync_q  <= 1'b0;
      clk_prev_q  <= 1'b0;
      load_meta_q <= 1'b1;
      load_sync_q <= 1'b1;
      state_q     <= ST_IDLE;
      sr_q        <= '1;
      cnt_q       <= 5'd0;
      done_q      <= 1'b0;
      wd_q        <= '0;
      link_q      <= 1'b0;
    end else begin
      clk_meta_q  <= JOY_CLK;
      clk_sync_q  <= clk_meta_q;
      clk_prev_q  <= clk_sync_q;
      load_meta_q <= JOY_LOAD;
      load_sync_q <= load_meta_q;
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      wd_q        <= wd_d;
      link_q      <= link_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    // An active load overrides everything, including a coincident shift.
    if (!load_sync_q) begin
      state_d = ST_LOAD;
      sr_d    = {~joystick1, ~joystick2};
      cnt_d   = 5'd0;
    end else begin
      case (state_q)
        ST_LOAD: state_d = ST_SHIFT;
        ST_SHIFT: begin
          if (clk_rise) begin
            sr_d  = {sr_q[FRAME-2:0], 1'b1};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == FRAME_LEN - 5'd1) begin
              done_d  = 1'b1;
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (clk_rise) sr_d = {sr_q[FRAME-2:0], 1'b1};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    wd_d   = wd_q;
    link_d = link_q;
    if (done_d) begin
      wd_d   = '0;
      link_d = 1'b1;
    end else begin
      if (wd_q != WD_MAX) wd_d = wd_q + WD_W'(1);
      if (wd_d == WD_MAX) link_d = 1'b0;
    end
  end

  assign JOY_DATA    = sr_q[FRAME-1];
  assign frame_done  = done_q;
  assign link_active = link_q;
  assign bit_count   = cnt_q;

endmodule

// File: tb/tb_joy_db15_responder.sv
// tb/tb_joy_db15_responder.sv - self-checking bench for joy_db15_responder
module tb_joy_db15_responder;

  localparam int B  = 12;
  localparam int TO = 100;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         jclk = 1'b0;
  logic         jload = 1'b1;
  logic [B-1:0] j1 = '0;
  logic [B-1:0] j2 = '0;
  logic         jdata, fd, la;
  logic [4:0]   bc;

  always #10 clk = ~clk;

  joy_db15_responder #(.BITS_PER_PLAYER(B), .TIMEOUT_CYCLES(TO)) dut (
    .Clk_50_I   (clk),
    .Reset_n    (rst_n),
    .JOY_CLK    (jclk),
    .JOY_LOAD   (jload),
    .joystick1  (j1),
    .joystick2  (j2),
    .JOY_DATA   (jdata),
    .frame_done (fd),
    .link_active(la),
    .bit_count  (bc)
  );

  int         total = 0;
  int         bad = 0;
  int         cyc_no = 0;
  int         fd_cnt = 0;
  int         fd_cyc = -1;
  int         la_fall_cyc = -1;
  logic       fd_la = 1'b0;
  logic [4:0] fd_bc = '0;
  logic       la_prev = 1'b0;

  always @(negedge clk) begin
    cyc_no++;
    if (fd) begin
      fd_cnt++;
      fd_cyc = cyc_no;
      fd_la  = la;
      fd_bc  = bc;
    end
    if (la_prev && !la) la_fall_cyc = cyc_no;
    la_prev = la;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bit i of the serial frame: inverted {player1, player2} MSB first, ones after the end.
  function automatic logic exp_bit(input logic [B-1:0] a, input logic [B-1:0] b, input int i);
    logic [2*B-1:0] w;
    w = ~{a, b};
    if (i >= 2 * B) return 1'b1;
    return w[2*B-1-i];
  endfunction

  task automatic do_load(input bit toggle);
    jload = 1'b0;
    cyc(3);
    check("load_latency", jdata, exp_bit(j1, j2, 0));
    if (toggle) begin
      repeat (3) begin
        jclk = 1'b1; cyc(5);
        jclk = 1'b0; cyc(5);
      end
      check("bc_during_load", bc, 0);
    end else begin
      cyc(7);
    end
    jload = 1'b1;
    cyc(10);
    check("bc_after_load", bc, 0);
    check("first_bit", jdata, exp_bit(j1, j2, 0));
  endtask

  task automatic run_frame(input logic [B-1:0] a, input logic [B-1:0] b,
                           input int nclk, input bit toggle);
    int fd0;
    j1 = a;
    j2 = b;
    do_load(toggle);
    fd0 = fd_cnt;
    for (int i = 1; i <= nclk; i++) begin
      jclk = 1'b1;
      cyc(4);
      check("shift_bit", jdata, exp_bit(a, b, i));
      check("bit_count", bc, (i > 2 * B) ? 2 * B : i);
      j1 = B'($urandom);
      j2 = B'($urandom);
      cyc(6);
      jclk = 1'b0;
      cyc(10);
    end
    check("frame_done_count", fd_cnt - fd0, (nclk >= 2 * B) ? 1 : 0);
    if (nclk >= 2 * B) begin
      check("link_at_done", fd_la, 1);
      check("bc_at_done", fd_bc, 2 * B);
    end
  endtask

  initial begin
    cyc(3);
    check("rst_data", jdata, 1);
    check("rst_fd", fd, 0);
    check("rst_link", la, 0);
    check("rst_bc", bc, 0);
    rst_n = 1'b1;
    cyc(3);

    run_frame(12'h001, 12'h800, 24, 1'b0);
    run_frame(B'($urandom), B'($urandom), 24, 1'b1);
    run_frame(B'($urandom), B'($urandom), 30, 1'b0);
    run_frame(B'($urandom), B'($urandom), 7, 1'b0);
    run_frame(B'($urandom), B'($urandom), $urandom_range(1, 23), 1'b0);
    for (int k = 0; k < 3; k++) run_frame(B'($urandom), B'($urandom), 24, 1'b0);

    run_frame(12'hFFF, 12'hFFF, 2, 1'b0);
    check("link_before_reset", la, 1);
    check("data_before_reset", jdata, 0);
    jclk = 1'b1;
    cyc(2);
    rst_n = 1'b0;
    #1;
    check("midrst_data", jdata, 1);
    check("midrst_bc", bc, 0);
    check("midrst_link", la, 0);
    cyc(2);
    jclk = 1'b0;
    rst_n = 1'b1;
    cyc(5);
    repeat (3) begin
      jclk = 1'b1; cyc(10);
      jclk = 1'b0; cyc(10);
    end
    check("postrst_data", jdata, 1);
    check("postrst_bc", bc, 0);

    run_frame(B'($urandom), B'($urandom), 24, 1'b0);
    cyc(150);
    check("wd_timeout_cycles", la_fall_cyc - fd_cyc, TO);
    check("wd_link_low", la, 0);
    run_frame(B'($urandom), B'($urandom), 24, 1'b0);
    check("wd_relink", la, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
